// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game state machine, round-robin AABB collision scan and score counter
module game_state_ctrl #(
    parameter int N_OBJ        = 4,
    parameter int XW           = 10,
    parameter int YW           = 10,
    parameter int WW           = 8,
    parameter int HW           = 8,
    parameter int TW           = 6,
    parameter int MARGIN       = 2,
    parameter int SW           = 16,
    parameter int SCORE_PERIOD = 1000,
    localparam int DW          = XW + YW + WW + HW + TW,
    localparam int HIW         = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic               clk3,
    input  logic               reset,
    input  logic               btn_start_n,
    input  logic               btn_pause_n,
    input  logic [DW-1:0]      player,
    input  logic [N_OBJ*DW-1:0] obj_bus,
    output logic               start,
    output logic               pause,
    output logic               game_over,
    output logic [HIW-1:0]     hit_index,
    output logic [SW-1:0]      score,
    output logic               scan_done
);

    localparam int CXW  = ((XW > WW) ? XW : WW) + 1;
    localparam int CYW  = ((YW > HW) ? YW : HW) + 1;
    localparam int DIVW = (SCORE_PERIOD > 1) ? $clog2(SCORE_PERIOD) : 1;
    localparam logic [HIW-1:0]  LAST_IDX = HIW'(N_OBJ - 1);
    localparam logic [DIVW-1:0] DIV_TC   = DIVW'(SCORE_PERIOD - 1);

    typedef enum logic [1:0] {S_TITLE, S_RUN, S_PAUSED, S_OVER} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_start_prev;
    logic            r_pause_prev;
    logic [HIW-1:0]  r_scan_idx;
    logic [DIVW-1:0] r_div;
    logic            r_start;
    logic            r_pause;
    logic            r_game_over;
    logic [HIW-1:0]  r_hit_index;
    logic [SW-1:0]   r_score;
    logic            r_scan_done;

    logic            w_press_s;
    logic            w_press_p;
    logic [DW-1:0]   w_obj;
    logic [XW-1:0]   w_px, w_ox;
    logic [YW-1:0]   w_py, w_oy;
    logic [WW-1:0]   w_pw, w_ow;
    logic [HW-1:0]   w_ph, w_oh;
    logic [TW-1:0]   w_ot;
    logic [CXW-1:0]  w_pxe, w_pxr, w_oxr;
    logic [CYW-1:0]  w_pye, w_pyb, w_oyb;
    logic            w_player_ok;
    logic            w_hit;
    logic            w_unused_ptype;

    assign w_press_s = r_start_prev & ~btn_start_n;
    assign w_press_p = r_pause_prev & ~btn_pause_n;

    assign w_px = player[XW-1:0];
    assign w_py = player[XW +: YW];
    assign w_pw = player[XW+YW +: WW];
    assign w_ph = player[XW+YW+WW +: HW];
    assign w_unused_ptype = ^player[DW-1 -: TW];

    // Select the obstacle record currently under scan
    always_comb begin
        w_obj = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (r_scan_idx == i[HIW-1:0]) begin
                w_obj = obj_bus[i*DW +: DW];
            end
        end
    end

    assign w_ox = w_obj[XW-1:0];
    assign w_oy = w_obj[XW +: YW];
    assign w_ow = w_obj[XW+YW +: WW];
    assign w_oh = w_obj[XW+YW+WW +: HW];
    assign w_ot = w_obj[DW-1 -: TW];

    // Inset hitbox; a player no larger than twice the margin has an empty box
    assign w_pxe = CXW'(w_px) + CXW'(MARGIN);
    assign w_pxr = CXW'(w_px) + CXW'(w_pw) - CXW'(MARGIN);
    assign w_pye = CYW'(w_py) + CYW'(MARGIN);
    assign w_pyb = CYW'(w_py) + CYW'(w_ph) - CYW'(MARGIN);
    assign w_oxr = CXW'(w_ox) + CXW'(w_ow);
    assign w_oyb = CYW'(w_oy) + CYW'(w_oh);
    assign w_player_ok = (32'(w_pw) > 32'(2 * MARGIN)) && (32'(w_ph) > 32'(2 * MARGIN));

    // Degenerate obstacles are excluded explicitly: a zero-width line strictly
    // inside the hitbox would otherwise pass the strict edge compares
    assign w_hit = (w_ot != '0) && (w_ow != '0) && (w_oh != '0) && w_player_ok &&
                   (w_pxe < w_oxr) && (CXW'(w_ox) < w_pxr) &&
                   (w_pye < w_oyb) && (CYW'(w_oy) < w_pyb);

    // Next-state decision; a collision outranks a pause press
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_TITLE:  if (w_press_s) w_state_next = S_RUN;
            S_RUN: begin
                if (w_hit)          w_state_next = S_OVER;
                else if (w_press_p) w_state_next = S_PAUSED;
            end
            S_PAUSED: if (w_press_p) w_state_next = S_RUN;
            S_OVER:   if (w_press_s) w_state_next = S_TITLE;
            default:  w_state_next = S_TITLE;
        endcase
    end

    // State register, registered outputs, scan pointer and score divider
    always_ff @(posedge clk3) begin
        if (reset) begin
            r_state      <= S_TITLE;
            r_start_prev <= btn_start_n;
            r_pause_prev <= btn_pause_n;
            r_scan_idx   <= '0;
            r_div        <= '0;
            r_start      <= 1'b0;
            r_pause      <= 1'b0;
            r_game_over  <= 1'b0;
            r_hit_index  <= '0;
            r_score      <= '0;
            r_scan_done  <= 1'b0;
        end else begin
            r_start_prev <= btn_start_n;
            r_pause_prev <= btn_pause_n;
            r_state      <= w_state_next;
            r_start      <= (w_state_next != S_TITLE);
            r_pause      <= (w_state_next == S_PAUSED) || (w_state_next == S_OVER);
            r_game_over  <= (w_state_next == S_OVER);
            r_scan_done  <= (r_state == S_RUN) && (r_scan_idx == LAST_IDX);
            case (r_state)
                S_TITLE: begin
                    r_scan_idx <= '0;
                    if (w_press_s) begin
                        r_score <= '0;
                        r_div   <= '0;
                    end
                end
                S_RUN: begin
                    if (w_hit) begin
                        r_hit_index <= r_scan_idx;
                        r_scan_idx  <= '0;
                    end else if (r_scan_idx == LAST_IDX) begin
                        r_scan_idx <= '0;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                    if (r_div == DIV_TC) begin
                        r_div <= '0;
                        if (r_score != {SW{1'b1}}) r_score <= r_score + 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_PAUSED: begin
                end
                S_OVER: begin
                    r_scan_idx <= '0;
                    if (w_press_s) r_hit_index <= '0;
                end
                default: r_scan_idx <= '0;
            endcase
        end
    end

    assign start     = r_start;
    assign pause     = r_pause;
    assign game_over = r_game_over;
    assign hit_index = r_hit_index;
    assign score     = r_score;
    assign scan_done = r_scan_done;

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Sits directly upstream of update_player and drives its `start` and `pause` inputs.
- Consumes the player object record produced by update_player and the packed obstacle records from the obstacle stage.
- Scans obstacles round-robin, one per clk3 cycle, with an axis-aligned bounding-box (AABB) overlap test.
- Runs the game state machine (title, run, paused, over) and keeps the score counter.

Parameters:
- N_OBJ, 4, number of obstacle slots on obj_bus
- XW, 10, x field width
- YW, 10, y field width
- WW, 8, width field width
- HW, 8, height field width
- TW, 6, type field width; type 0 = empty slot
- MARGIN, 2, player hitbox inset in pixels, applied on every side
- SW, 16, score width
- SCORE_PERIOD, 1000, RUN cycles per score point
- Derived (local): DW = XW+YW+WW+HW+TW
- Record layout, LSB first: x, y, width, height, type.

Ports:
- clk3, in, 1: game clock.
- reset, in, 1: synchronous, active-high reset.
- btn_start_n, in, 1: start button, active-low level.
- btn_pause_n, in, 1: pause button, active-low level.
- player, in, DW: player record from update_player.
- obj_bus, in, N_OBJ*DW: obstacle records; slot i occupies bits [i*DW +: DW].
- start, out, 1: game started (to update_player and the obstacle stage).
- pause, out, 1: motion freeze.
- game_over, out, 1: collision has occurred.
- hit_index, out, clog2(N_OBJ) (min 1): slot index that caused game over.
- score, out, SW: current score.
- scan_done, out, 1: one-cycle pulse when the last slot is checked.

Behaviour:
- All registers update on posedge clk3. reset has priority over everything.
- Reset values:
  - state = TITLE
  - start = 0, pause = 0, game_over = 0
  - hit_index = 0, score = 0, scan_done = 0
  - scan_idx = 0, score divider = 0
  - start_prev / pause_prev load the current button levels, so a button held through reset does not fire.
- Edge detection:
  - press_s = start_prev & ~btn_start_n. press_p is defined the same way on the pause button.
  - The prev registers load the button level every cycle.
  - A state change is visible one cycle after the first low sample.
- State machine (outputs are registered and track the state):
  - TITLE: start=0, pause=0, game_over=0. press_s → RUN; this transition clears score and the divider and sets scan_idx=0.
  - RUN: start=1, pause=0.
    - Collision hit → OVER.
    - Otherwise press_p → PAUSED.
    - press_s is ignored.
  - PAUSED: start=1, pause=1.
    - press_p → RUN.
    - scan_idx, score and divider hold.
    - No collision checks are made.
  - OVER: start=1, pause=1, game_over=1. press_s → TITLE, which clears game_over and sets hit_index=0.
- Simultaneous events: a collision and press_p in the same RUN cycle → OVER (collision wins).
- Scan (RUN only):
  - Slot scan_idx is evaluated every cycle.
  - scan_idx increments and wraps N_OBJ-1 → 0.
  - scan_done = 1 in the cycle after slot N_OBJ-1 is evaluated; otherwise 0.
  - In TITLE and OVER, scan_idx = 0.
- Collision test for slot i:
  - The slot is valid when type != 0.
  - Player hitbox:
    - pxe = px + MARGIN, pxr = px + pw − MARGIN.
    - pye = py + MARGIN, pyb = py + ph − MARGIN.
    - If pw ≤ 2*MARGIN or ph ≤ 2*MARGIN, the player can never collide.
  - Hit condition (all must hold):
    - pxe < ox+ow
    - ox < pxr
    - pye < oy+oh
    - oy < pyb
  - Comparisons are strict: touching edges do not collide. Zero-width or zero-height obstacles never hit.
  - All sums are computed one bit wider than the wider operand, so there is no wrap.
  - On a hit: hit_index ← i and state ← OVER at the same edge.
- Score (RUN only):
  - The divider counts 0 … SCORE_PERIOD−1.
  - At terminal count the divider returns to 0 and score increments.
  - Score saturates at 2^SW−1.
  - Score holds in PAUSED and OVER.
- Inputs are not registered beyond edge detection. The player and obj_bus records are sampled combinationally on the evaluation cycle.

Test Plan:
1. reset high 2 cycles with btn_start_n=0 held → all outputs 0, state TITLE. Release reset with button still low → no transition. Release then press (1→0) → start=1 one cycle later, score=0.
2. RUN; player x=50,y=100,w=20,h=20, MARGIN=2; slot 2 = {x=67,y=110,w=10,h=10,type=3}; other slots type 0 → within 4 cycles game_over=1, pause=1, hit_index=2, scan_idx=0.
3. Same setup with obstacle x=68 (68 = pxr, edges touch) → no hit over 100 cycles. scan_done pulses every 4th cycle.
4. RUN for 3000 cycles with SCORE_PERIOD=1000 → score=3. Press pause → pause=1 and score holds 3 over 5000 cycles. Press pause again → resumes and counts.
5. Same cycle: overlapping slot 0 evaluated and btn_pause_n falling → state OVER, not PAUSED. Then press start → TITLE with game_over=0, hit_index=0, start=0.
6. Mid-RUN (score=7, scan_idx=1) assert reset for 1 cycle → next cycle state TITLE, score=0, scan_idx=0, pause=0. SW=4 with SCORE_PERIOD=1 → score saturates at 15.
